// File: rtl/prog_fetch.sv
// prog_fetch: sequential instruction-fetch stage in front of the core.
//
// Holds a 2**ADDR_W byte program store written through a byte-wide loader
// port, and assembles each instruction from BYTES consecutive bytes, one
// byte per clock.
// Bytes are assembled big-endian: the byte at the base address lands in the
// most significant byte of the word.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   load_en    write one program byte this cycle
//   load_addr  byte address for the loader write
//   load_data  byte to write
//   pc_addr    byte address of the instruction (core program counter)
//   fetch_req  request a fetch starting at pc_addr
//   inst       assembled instruction, big-endian
//   inst_valid inst holds a complete, coherent instruction
//   busy       fetch in progress
module prog_fetch #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [7:0]           load_data,
  input  logic [ADDR_W-1:0]    pc_addr,
  input  logic                 fetch_req,
  output logic [8*BYTES-1:0]   inst,
  output logic                 inst_valid,
  output logic                 busy
);

  localparam int unsigned W      = 8 * BYTES;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned BEAT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTES - 1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q,  base_d;
  logic [BEAT_W-1:0]   beat_q,  beat_d;
  // Only the first BYTES-1 bytes need holding; the last byte is taken
  // straight from the store on the final beat.
  logic [W-9:0]        shadow_q, shadow_d;
  logic [W-1:0]        inst_q,  inst_d;
  logic                valid_q, valid_d;
  logic                busy_q,  busy_d;

  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr;
  logic [7:0]          rd_byte;
  logic [W-1:0]        assembled;

  // Program store: synchronous write, never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign rd_ptr    = base_q + ADDR_W'(beat_q);
  assign rd_byte   = mem[rd_ptr];
  assign assembled = {shadow_q, rd_byte};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          // A write takes priority; any pending request must be held.
          valid_d = 1'b0;
        end else if (fetch_req) begin
          base_d  = pc_addr;
          beat_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end

      READ: begin
        if (load_en) begin
          // The store changed under us: restart from the latched base so the
          // completed word is coherent with the latest contents.
          beat_d  = '0;
          valid_d = 1'b0;
        end else begin
          shadow_d = assembled[W-9:0];
          if (beat_q == LAST_BEAT) begin
            inst_d  = assembled;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      beat_q   <= '0;
      shadow_q <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      shadow_q <= shadow_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_prog_fetch.sv
module tb_prog_fetch;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [7:0]  load_data;
  logic [4:0]  pc_addr;
  logic        fetch_req;
  logic [31:0] inst;
  logic        inst_valid;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  prog_fetch #(.ADDR_W(5), .BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .pc_addr    (pc_addr),
    .fetch_req  (fetch_req),
    .inst       (inst),
    .inst_valid (inst_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_inst,
                         input logic e_valid, input logic e_busy);
    chk({tag, ".inst"},  inst, e_inst);
    chk({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, e_valid});
    chk({tag, ".busy"},  {31'b0, busy}, {31'b0, e_busy});
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [4:0] a);
    fetch_req = 1'b1; pc_addr = a;
    step();
    fetch_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    pc_addr = '0; fetch_req = 1'b0;
    step();
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic fetch at 4: busy for 4 cycles, inst stays 0 until completion.
    load(5'd4, 8'h07); load(5'd5, 8'h00); load(5'd6, 8'h09); load(5'd7, 8'h00);
    fetch(5'd4);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("f4_beat%0d", i), 32'h0, 1'b0, 1'b1);
      step();
    end
    chk_out("f4_done", 32'h07000900, 1'b1, 1'b0);

    // Write after valid: valid drops, inst holds.
    load(5'd20, 8'h11);
    chk_out("load_clears_valid", 32'h07000900, 1'b0, 1'b0);

    // Wrap-around fetch at 30.
    load(5'd30, 8'hAA); load(5'd31, 8'hBB); load(5'd0, 8'hCC); load(5'd1, 8'hDD);
    fetch(5'd30);
    step(); step(); step();
    chk_out("wrap_pre", 32'h07000900, 1'b0, 1'b1);
    step();
    chk_out("wrap_done", 32'hAABBCCDD, 1'b1, 1'b0);

    // Mid-fetch write restarts the fetch.
    load(5'd8, 8'h08); load(5'd9, 8'h00); load(5'd10, 8'h00); load(5'd11, 8'h00);
    fetch(5'd8);
    step();
    load(5'd9, 8'h5A);
    chk_out("mid_w0", 32'hAABBCCDD, 1'b0, 1'b1);
    step(); step(); step();
    chk_out("mid_w3", 32'hAABBCCDD, 1'b0, 1'b1);
    step();
    chk_out("mid_done", 32'h085A0000, 1'b1, 1'b0);

    // Busy collision: second request while reading is ignored.
    load(5'd2, 8'h12); load(5'd3, 8'h34);
    load(5'd16, 8'hDE); load(5'd17, 8'hAD); load(5'd18, 8'hBE); load(5'd19, 8'hEF);
    fetch_req = 1'b1; pc_addr = 5'd0;
    step();
    pc_addr = 5'd16;
    step(); step();
    fetch_req = 1'b0;
    step(); step();
    chk_out("coll_done", 32'hCCDD1234, 1'b1, 1'b0);
    step();
    chk_out("coll_hold", 32'hCCDD1234, 1'b1, 1'b0);
    fetch(5'd16);
    step(); step(); step(); step();
    chk_out("coll_refetch", 32'hDEADBEEF, 1'b1, 1'b0);

    // A write in IDLE blocks acceptance of a simultaneous request.
    load_en = 1'b1; load_addr = 5'd21; load_data = 8'h00;
    fetch_req = 1'b1; pc_addr = 5'd4;
    step();
    load_en = 1'b0;
    chk_out("load_blocks_req", 32'hDEADBEEF, 1'b0, 1'b0);
    step();
    fetch_req = 1'b0;
    chk("held_req_accepted", {31'b0, busy}, 32'd1);
    step(); step(); step(); step();
    chk_out("held_req_done", 32'h07000900, 1'b1, 1'b0);

    // Asynchronous reset in the 3rd READ cycle, between edges.
    fetch(5'd16);
    step(); step();
    #2 rst = 1'b1;
    #1 chk_out("rst_async", 32'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    chk_out("rst_after", 32'h0, 1'b0, 1'b0);
    fetch(5'd16);
    step(); step(); step(); step();
    chk_out("rst_refetch", 32'hDEADBEEF, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_fetch.md
Name: prog_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the processor core. It holds the 32-byte program store and a byte-wide loader port, and assembles each 32-bit instruction from four consecutive bytes. Bytes are read one per clock, and each completed instruction is presented with a valid flag. It replaces the combinational four-byte read with a real sequential, stallable fetch.

Parameters:
ADDR_W, 5, byte-address width; the program store holds 2**ADDR_W bytes
BYTES, 4, bytes per instruction; fixed at 4 because the instruction is 32 bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
load_en  input  1  write one program byte this cycle
load_addr  input  5  byte address for the loader write
load_data  input  8  byte to write
pc_addr  input  5  byte address of the instruction (the core's program counter)
fetch_req  input  1  request a fetch starting at pc_addr
inst  output  32  assembled instruction, big-endian
inst_valid  output  1  inst holds a complete, coherent instruction
busy  output  1  fetch in progress

Behaviour:
- Reset (async, active-high): inst=32'h0, inst_valid=0, busy=0, FSM to IDLE, beat counter=0. Program store contents are not cleared by reset.
- Program store: 2**ADDR_W x 8 array.
  - Write is synchronous: at a clk edge with load_en=1, mem[load_addr]<=load_data.
  - Read is combinational from an internal read pointer.
- FSM states: IDLE, READ, each evaluated at the rising edge.
- IDLE:
  - Condition: fetch_req=1 and load_en=0 at an edge.
  - Actions at that edge: base<=pc_addr, beat<=0, inst_valid<=0, busy<=1, go to READ.
  - fetch_req=0: stay in IDLE. inst and inst_valid hold.
- READ:
  - Each edge shifts in mem[(base+beat) mod 2**ADDR_W] and then increments beat.
  - Byte order: the byte at base lands in inst[31:24], base+1 in [23:16], base+2 in [15:8], base+3 in [7:0].
  - Partial shift results must not be visible on inst. Assemble in a shadow register and copy it to inst on the final beat.
  - When beat reaches 3: inst<=assembled word, inst_valid<=1, busy<=0, go to IDLE.
- Latency: inst_valid rises at the 4th edge after the edge that accepted fetch_req. The next request is accepted at the following edge at the earliest, giving 5 cycles per instruction back-to-back.
- Address wrap-around: byte addresses are computed mod 2**ADDR_W, so base=30 reads bytes 30, 31, 0, 1.
- fetch_req while busy: ignored. pc_addr changes during READ have no effect, because base is latched.
- load_en priority:
  - A write always completes in the cycle it is presented.
  - In IDLE, load_en blocks acceptance of fetch_req in that cycle; the request must be held.
  - Any write clears inst_valid (inst value holds), so a stale instruction is never flagged valid.
  - A write during READ restarts the fetch: beat<=0 with the same base, busy stays 1. Completion is therefore 4 edges after the last write.
- Reset mid-fetch: aborts immediately. Outputs take reset values and no partial word is ever exposed.
- A new accepted fetch clears inst_valid at the accepting edge. inst keeps the previous word until the new one completes.

Test Plan:
- Load bytes 4..7 = 07,00,09,00; then pulse fetch_req with pc_addr=4. Required: busy=1 for 4 cycles, then inst=32'h07000900 with inst_valid=1. inst must be unchanged from 0 before completion.
- Wrap-around: load bytes 30,31,0,1 = AA,BB,CC,DD; fetch with pc_addr=30. Required: inst=32'hAABBCCDD.
- Mid-fetch load: start a fetch at 8 (bytes 08,00,00,00), then write byte 9=5A on the 2nd READ cycle. Required: fetch restarts; completion lands 4 edges after the write with inst=32'h085A0000.
- Busy collision: fetch_req at 0, then fetch_req with pc_addr=16 on the next two cycles. Required: second request ignored and inst holds the word at 0. A fresh request after completion fetches 16.
- Reset mid-fetch: assert rst on the 3rd READ cycle, asynchronously between edges. Required: inst=0, inst_valid=0, busy=0 immediately. Program bytes are retained, so a refetch returns the original word.
- Loader/valid interaction: after a valid inst, write any byte. Required: inst_valid drops at that edge and inst is unchanged.
